// File: rtl/sparse_weight_encoder.sv
// Dense-to-sparse weight tile encoder: streams a ROWSxCOLS tile in row-major order
// and emits (row, col, value) entries, per-row end pointers and a total count.

module nz_slot #(
    parameter int RW    = 2,
    parameter int KW    = 3,
    parameter int VAL_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [RW-1:0]    i_r,
    input  logic [KW-1:0]    i_k,
    input  logic [VAL_W-1:0] i_val,
    output logic [RW-1:0]    o_r,
    output logic [KW-1:0]    o_k,
    output logic [VAL_W-1:0] o_val
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r   <= '0;
            o_k   <= '0;
            o_val <= '0;
        end else if (i_we) begin
            o_r   <= i_r;
            o_k   <= i_k;
            o_val <= i_val;
        end
    end
endmodule

module sparse_weight_encoder #(
    parameter  int ROWS   = 3,
    parameter  int COLS   = 8,
    parameter  int VAL_W  = 8,
    parameter  int MAX_NZ = 24,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int KW     = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW     = $clog2(MAX_NZ + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [VAL_W-1:0] i_data,
    output logic             o_ready,
    output logic [RW-1:0]    o_r   [0:MAX_NZ-1],
    output logic [KW-1:0]    o_k   [0:MAX_NZ-1],
    output logic [VAL_W-1:0] o_val [0:MAX_NZ-1],
    output logic [NW-1:0]    o_ptr [0:ROWS-1],
    output logic [NW-1:0]    o_length,
    output logic             o_busy,
    output logic             o_finish,
    output logic             o_overflow
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [KW-1:0]     col_q, col_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     len_q, len_d;
    logic [NW-1:0]     ptr_q [0:ROWS-1];
    logic [NW-1:0]     ptr_d [0:ROWS-1];
    logic              ovf_q, ovf_d;
    logic              ready_q, busy_q, fin_q;
    logic              wr_en;
    logic [MAX_NZ-1:0] slot_we;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    for (int r = 0; r < ROWS; r++) ptr_d[r] = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (i_valid) begin
                    if (i_data != '0) begin
                        // Saturate at MAX_NZ: drop the entry but remember it happened.
                        if (cnt_q != NW'(MAX_NZ)) begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + NW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (col_q == KW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                        for (int r = 0; r < ROWS; r++)
                            if (row_q == RW'(r)) ptr_d[r] = cnt_d;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d   = '0;
                            len_d   = cnt_d;
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + KW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++) ptr_q[r] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d == SCAN);
            busy_q  <= (state_d == SCAN);
            fin_q   <= (state_d == DONE);
            ptr_q   <= ptr_d;
        end
    end

    // One storage slot per possible nonzero; only the slot at the current count loads.
    for (genvar g = 0; g < MAX_NZ; g++) begin : g_slot
        assign slot_we[g] = wr_en && (cnt_q == NW'(g));
        nz_slot #(.RW(RW), .KW(KW), .VAL_W(VAL_W)) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (slot_we[g]),
            .i_r     (row_q),
            .i_k     (col_q),
            .i_val   (i_data),
            .o_r     (o_r[g]),
            .o_k     (o_k[g]),
            .o_val   (o_val[g])
        );
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_finish   = fin_q;
    assign o_overflow = ovf_q;
    assign o_length   = len_q;
    assign o_ptr      = ptr_q;
endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Bench for sparse_weight_encoder: a default instance and a MAX_NZ=20 instance share
// stimulus; a tile-level model checks both every cycle, plus literal spot checks.

module tb_sparse_weight_encoder;
    localparam int ROWS = 3, COLS = 8, N = ROWS * COLS;

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_valid = 1'b0;
    logic [7:0] i_data = '0;

    logic       a_ready, a_busy, a_fin, a_ovf, b_ready, b_busy, b_fin, b_ovf;
    logic [1:0] a_r [0:23];
    logic [2:0] a_k [0:23];
    logic [7:0] a_v [0:23];
    logic [4:0] a_ptr [0:2];
    logic [4:0] a_len;
    logic [1:0] b_r [0:19];
    logic [2:0] b_k [0:19];
    logic [7:0] b_v [0:19];
    logic [4:0] b_ptr [0:2];
    logic [4:0] b_len;

    sparse_weight_encoder u_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
        .i_data(i_data), .o_ready(a_ready), .o_r(a_r), .o_k(a_k), .o_val(a_v),
        .o_ptr(a_ptr), .o_length(a_len), .o_busy(a_busy), .o_finish(a_fin),
        .o_overflow(a_ovf));

    sparse_weight_encoder #(.MAX_NZ(20)) u_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
        .i_data(i_data), .o_ready(b_ready), .o_r(b_r), .o_k(b_k), .o_val(b_v),
        .o_ptr(b_ptr), .o_length(b_len), .o_busy(b_busy), .o_finish(b_fin),
        .o_overflow(b_ovf));

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Both instances folded into common arrays so one checker serves them.
    int act_r [2][N], act_k [2][N], act_v [2][N], act_ptr [2][ROWS];
    int act_len [2], act_ovf [2], act_rdy [2], act_bsy [2], act_fin [2];
    always_comb begin
        for (int i = 0; i < N; i++) begin
            act_r[0][i] = a_r[i]; act_k[0][i] = a_k[i]; act_v[0][i] = a_v[i];
            act_r[1][i] = 0;      act_k[1][i] = 0;      act_v[1][i] = 0;
        end
        for (int i = 0; i < 20; i++) begin
            act_r[1][i] = b_r[i]; act_k[1][i] = b_k[i]; act_v[1][i] = b_v[i];
        end
        for (int r = 0; r < ROWS; r++) begin
            act_ptr[0][r] = a_ptr[r]; act_ptr[1][r] = b_ptr[r];
        end
        act_len = '{a_len, b_len};
        act_ovf = '{a_ovf, b_ovf};
        act_rdy = '{a_ready, b_ready};
        act_bsy = '{a_busy, b_busy};
        act_fin = '{a_fin, b_fin};
    end

    // Tile-level model: collect accepted dense beats, derive the sparse form at the end.
    int maxnz [2] = '{24, 20};
    int exp_r [2][N], exp_k [2][N], exp_v [2][N], exp_ptr [2][ROWS], exp_len [2], exp_ovf [2];
    bit m_scan, m_fin, m_have;
    int dense [$];

    task automatic encode(input int d);
        int cnt = 0;
        exp_ovf[d] = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                if (dense[r*COLS + k] != 0) begin
                    if (cnt < maxnz[d]) begin
                        exp_r[d][cnt] = r; exp_k[d][cnt] = k; exp_v[d][cnt] = dense[r*COLS + k];
                        cnt++;
                    end else exp_ovf[d] = 1;
                end
            end
            exp_ptr[d][r] = cnt;
        end
        exp_len[d] = cnt;
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                m_scan = 0; m_fin = 0; m_have = 1; dense.delete();
                for (int d = 0; d < 2; d++) begin
                    exp_len[d] = 0; exp_ovf[d] = 0;
                    for (int r = 0; r < ROWS; r++) exp_ptr[d][r] = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("ready[%0d]", d), act_rdy[d], int'(m_scan));
                    chk($sformatf("busy[%0d]", d), act_bsy[d], int'(m_scan));
                    chk($sformatf("finish[%0d]", d), act_fin[d], int'(m_fin));
                    if (m_have && !m_scan) begin
                        chk($sformatf("length[%0d]", d), act_len[d], exp_len[d]);
                        chk($sformatf("overflow[%0d]", d), act_ovf[d], exp_ovf[d]);
                        for (int r = 0; r < ROWS; r++)
                            chk($sformatf("ptr[%0d][%0d]", d, r), act_ptr[d][r], exp_ptr[d][r]);
                        for (int i = 0; i < exp_len[d]; i++) begin
                            chk($sformatf("r[%0d][%0d]", d, i), act_r[d][i], exp_r[d][i]);
                            chk($sformatf("k[%0d][%0d]", d, i), act_k[d][i], exp_k[d][i]);
                            chk($sformatf("val[%0d][%0d]", d, i), act_v[d][i], exp_v[d][i]);
                        end
                    end
                end
                if (m_fin) m_fin = 0;
                else if (m_scan) begin
                    if (i_valid) begin
                        dense.push_back(int'(i_data));
                        if (dense.size() == N) begin
                            encode(0); encode(1);
                            m_scan = 0; m_fin = 1; m_have = 1;
                        end
                    end
                end else if (i_start) begin
                    m_scan = 1; m_have = 0; dense.delete();
                end
            end
        end
    end

    logic [7:0] t_zero [N], t_sparse [N], t_ones [N];

    task automatic run_tile(input logic [7:0] t [N], input bit gaps, input int start_at);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            i_valid = 1'b1; i_data = t[i];
            i_start = (i == start_at);
            @(posedge i_clk); #1;
            i_start = 1'b0;
            if (gaps && i != N - 1) begin
                i_valid = 1'b0; i_data = 8'hAA;
                @(posedge i_clk); #1;
            end
        end
        i_valid = 1'b0; i_data = '0;
        for (int c = 0; c < 8 && !a_fin; c++) begin
            @(posedge i_clk); #1;
        end
        chk("finish_seen_a", int'(a_fin), 1);
        chk("finish_seen_b", int'(b_fin), 1);
    endtask

    task automatic lit_sparse();
        chk("lit_len", int'(a_len), 3);
        chk("lit_r0", int'(a_r[0]), 0); chk("lit_r1", int'(a_r[1]), 1); chk("lit_r2", int'(a_r[2]), 2);
        chk("lit_k0", int'(a_k[0]), 1); chk("lit_k1", int'(a_k[1]), 7); chk("lit_k2", int'(a_k[2]), 0);
        chk("lit_v0", int'(a_v[0]), 5); chk("lit_v1", int'(a_v[1]), 9); chk("lit_v2", int'(a_v[2]), 3);
        chk("lit_p0", int'(a_ptr[0]), 1); chk("lit_p1", int'(a_ptr[1]), 2); chk("lit_p2", int'(a_ptr[2]), 3);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            int nz = 0;
            for (int i = 0; i < N; i++) nz += int'(act_r[d][i] != 0 || act_k[d][i] != 0 || act_v[d][i] != 0);
            for (int r = 0; r < ROWS; r++) nz += int'(act_ptr[d][r] != 0);
            chk($sformatf("%s_arrays[%0d]", tag, d), nz, 0);
            chk($sformatf("%s_len[%0d]", tag, d), act_len[d], 0);
            chk($sformatf("%s_flags[%0d]", tag, d), act_rdy[d] + act_bsy[d] + act_fin[d] + act_ovf[d], 0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_zero[i] = '0; t_sparse[i] = '0; t_ones[i] = 8'd1;
        end
        t_sparse[1] = 8'd5; t_sparse[15] = 8'd9; t_sparse[16] = 8'd3;

        repeat (3) @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_tile(t_zero, 1'b0, -1);
        chk("zero_len", int'(a_len), 0);
        chk("zero_ovf", int'(a_ovf), 0);
        @(posedge i_clk); #1;

        run_tile(t_sparse, 1'b0, -1);
        lit_sparse();
        @(posedge i_clk); #1;

        run_tile(t_ones, 1'b0, -1);
        chk("ones_b_len", int'(b_len), 20);
        chk("ones_b_ovf", int'(b_ovf), 1);
        chk("ones_b_p0", int'(b_ptr[0]), 8); chk("ones_b_p1", int'(b_ptr[1]), 16);
        chk("ones_b_p2", int'(b_ptr[2]), 20);
        chk("ones_b_r19", int'(b_r[19]), 2); chk("ones_b_k19", int'(b_k[19]), 3);
        chk("ones_a_len", int'(a_len), 24);
        chk("ones_a_ovf", int'(a_ovf), 0);
        @(posedge i_clk); #1;

        // Back-to-back all-zero tile must clear the sticky overflow.
        run_tile(t_zero, 1'b0, -1);
        chk("b2b_b_len", int'(b_len), 0);
        chk("b2b_b_ovf", int'(b_ovf), 0);
        @(posedge i_clk); #1;

        run_tile(t_sparse, 1'b1, 5);
        lit_sparse();
        @(posedge i_clk); #1;

        // Reset after 10 beats of a tile discards it entirely.
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_data = t_ones[i];
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0; i_data = '0;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        chk_zero("midrst");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_tile(t_sparse, 1'b0, -1);
        lit_sparse();
        repeat (3) @(posedge i_clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sparse_weight_encoder.md
# sparse_weight_encoder

Compresses a dense weight tile, streamed in one element per cycle, into the sparse (row, column, row-pointer) format consumed by the RF address generator. For each nonzero weight it records the filter row, column index and value, and builds a cumulative per-row pointer array and a total nonzero count. It sits between the weight loader and the address-generation stage and is the writer of the sparse weight format that stage reads.

## Interface
- ROWS, 3, filter rows per tile (r index range)
- COLS, 8, columns per row (k index range)
- VAL_W, 8, weight value width; zero means no entry
- MAX_NZ, 24, maximum stored nonzeros (≤ ROWS*COLS)
- RW = $clog2(ROWS), KW = $clog2(COLS), NW = $clog2(MAX_NZ+1), derived
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin a new tile (sampled in IDLE only)
- i_valid  in  1  i_data holds a valid dense element
- i_data  in  VAL_W  dense weight, row-major (r outer, k inner)
- o_ready  out  1  encoder accepts a beat this cycle
- o_r[0:MAX_NZ-1]  out  RW each  row of i-th nonzero
- o_k[0:MAX_NZ-1]  out  KW each  column of i-th nonzero
- o_val[0:MAX_NZ-1]  out  VAL_W each  value of i-th nonzero
- o_ptr[0:ROWS-1]  out  NW each  nonzeros in rows 0..r inclusive (end pointer)
- o_length  out  NW  total stored nonzeros
- o_busy  out  1  high in SCAN
- o_finish  out  1  one-cycle pulse, tile complete
- o_overflow  out  1  sticky: a nonzero was dropped because MAX_NZ reached

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: o_ready=0. On i_start: clear row/col counters, count, o_ptr, o_overflow; go SCAN. Stored arrays keep old contents until overwritten (entries ≥ o_length are don't-care).
- SCAN: o_ready=1. A beat is accepted when i_valid&&o_ready; no accept → no state change.
- Accepted beat, i_data≠0, count<MAX_NZ: write o_r[count]=row, o_k[count]=col, o_val[count]=i_data; count+1.
- Accepted beat, i_data≠0, count==MAX_NZ: drop, set o_overflow; count unchanged.
- Accepted beat, i_data==0: nothing stored.
- Column wrap: at col==COLS-1, col→0, row+1, and o_ptr[row] written with the post-beat count (includes the current beat).
- Last beat (row==ROWS-1, col==COLS-1) → DONE. o_length = count.
- DONE: o_finish=1 for exactly that cycle; → IDLE.
- i_start while in SCAN or DONE is ignored.
- All outputs are registered; arrays stable from o_finish until next accepted beat of a subsequent tile.

## Timing
- Reset: state IDLE; o_ready, o_busy, o_finish, o_overflow = 0; o_length=0; all o_r/o_k/o_val/o_ptr = 0.
- i_start at cycle t → SCAN, o_ready=1 at t+1.
- Full-rate tile: ROWS*COLS accepted beats in consecutive cycles; o_finish at the cycle after the last beat; o_ready deasserts that same cycle.
- Min tile-to-tile: i_start accepted the cycle after o_finish (IDLE).
- Reset mid-SCAN: immediate return to reset values; partial tile discarded.
- Count arithmetic: NW bits, never exceeds MAX_NZ; o_ptr monotonic non-decreasing, o_ptr[ROWS-1]==o_length.

## Test plan
- All-zero tile (24 zeros, default params) → o_finish once, o_length=0, o_ptr={0,0,0}, o_overflow=0.
- Tile with nonzeros at (0,1)=5, (1,7)=9, (2,0)=3 → o_length=3, o_r={0,1,2}, o_k={1,7,0}, o_val={5,9,3}, o_ptr={1,2,3}.
- All-ones tile with MAX_NZ=20 → o_length=20, o_overflow=1, o_ptr={8,16,20}; entry 19 = (r=2,k=3).
- Same tile as scenario 2 with i_valid deasserted every other cycle → identical outputs; o_finish delayed, o_ready held high throughout SCAN.
- i_start pulsed mid-SCAN → ignored, tile completes normally; assert i_rst_n low after 10 beats → all outputs zero next cycle, new i_start encodes a fresh tile correctly.
- Back-to-back tiles (i_start the cycle after o_finish, second tile all zero) → second o_length=0, o_overflow cleared.
